fetch: RTL and testbench

Fetch stage of the 24-bit pipelined processor. Drives the instruction-memory request port, tracks the fetch PC, absorbs variable memory latency and decode stalls with a one-entry hold buffer, and loads the Fetch/Decode pipeline register that supplies `InstrD`/`PCPlus8D` to the decode stage. Applies PC redirects from writeback (`PCSrcW`) and execute (`BranchTakenE`).

---
 rtl/fetch.sv | 198 +++++++++++++++++++
 tb/tb_fetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Fetch stage: issues instruction-memory requests, keeps one response across decode stalls and loads the F/D register.
// Define FETCH_PERF_CNT_EN to add the FetchCount/BubbleCount performance counters.
module fetch #(
    parameter int unsigned  N        = 24,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         PCSrcW,
    input  logic [N-1:0] ResultW,
    input  logic         BranchTakenE,
    input  logic [N-1:0] ALUResultE,
    output logic         ImemReq,
    output logic [N-1:0] ImemAddr,
    input  logic [N-1:0] ImemRData,
    input  logic         ImemValid,
    output logic [N-1:0] InstrD,
    output logic [N-1:0] PCPlus8D,
    output logic         ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  FetchCount,
    output logic [31:0]  BubbleCount
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DISCARD,
        S_HOLD
    } state_t;

    localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

    state_t       state_q, state_d;
    logic [N-1:0] pcF_q, pcF_d;
    logic [N-1:0] reqAddr_q, reqAddr_d;
    logic [N-1:0] holdInstr_q, holdInstr_d;
    logic [N-1:0] holdPc_q, holdPc_d;
    logic [N-1:0] instrD_q, instrD_d;
    logic [N-1:0] pcPlus8D_q, pcPlus8D_d;
    logic         validD_q, validD_d;

    logic         redirect;
    logic         consume;
    logic [N-1:0] target;
    logic [N-1:0] pcPlus4;
    logic         instrValid;
    logic [N-1:0] instr;
    logic [N-1:0] instrPc;

    always_comb begin
        redirect = PCSrcW | BranchTakenE;
        consume  = ~StallD & ~FlushD;
        target   = (PCSrcW ? ResultW : ALUResultE) & ALIGN_MASK;
        pcPlus4  = pcF_q + N'(4);
    end

    // Request/hold sequencing; instrValid flags an instruction ready for the F/D register this cycle.
    always_comb begin
        state_d     = state_q;
        pcF_d       = pcF_q;
        reqAddr_d   = reqAddr_q;
        holdInstr_d = holdInstr_q;
        holdPc_d    = holdPc_q;
        instrValid  = 1'b0;
        instr       = '0;
        instrPc     = '0;

        case (state_q)
            S_FETCH: begin
                if (ImemValid) begin
                    if (redirect) begin
                        reqAddr_d = target;
                    end else if (consume) begin
                        instrValid = 1'b1;
                        instr      = ImemRData;
                        instrPc    = pcF_q;
                        pcF_d      = pcPlus4;
                        reqAddr_d  = pcPlus4;
                    end else begin
                        holdInstr_d = ImemRData;
                        holdPc_d    = pcF_q;
                        state_d     = S_HOLD;
                    end
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (ImemValid) begin
                    reqAddr_d = redirect ? target : pcF_q;
                    state_d   = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    reqAddr_d = target;
                    state_d   = S_FETCH;
                end else if (consume) begin
                    instrValid = 1'b1;
                    instr      = holdInstr_q;
                    instrPc    = holdPc_q;
                    pcF_d      = pcPlus4;
                    reqAddr_d  = pcPlus4;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (redirect) begin
            pcF_d = target;
        end
    end

    // F/D register: flush beats stall; an unstalled cycle without an instruction inserts a bubble.
    always_comb begin
        instrD_d   = instrD_q;
        pcPlus8D_d = pcPlus8D_q;
        validD_d   = validD_q;

        if (FlushD) begin
            instrD_d   = '0;
            pcPlus8D_d = '0;
            validD_d   = 1'b0;
        end else if (!StallD) begin
            if (instrValid) begin
                instrD_d   = instr;
                pcPlus8D_d = instrPc + N'(8);
                validD_d   = 1'b1;
            end else begin
                instrD_d = '0;
                validD_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pcF_q       <= RESET_PC;
            reqAddr_q   <= RESET_PC;
            holdInstr_q <= '0;
            holdPc_q    <= '0;
            instrD_q    <= '0;
            pcPlus8D_q  <= '0;
            validD_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            reqAddr_q   <= reqAddr_d;
            holdInstr_q <= holdInstr_d;
            holdPc_q    <= holdPc_d;
            instrD_q    <= instrD_d;
            pcPlus8D_q  <= pcPlus8D_d;
            validD_q    <= validD_d;
        end
    end

    // Gated by rst so no request is visible while reset is held.
    assign ImemReq  = ~rst & (state_q != S_HOLD);
    assign ImemAddr = reqAddr_q;
    assign InstrD   = instrD_q;
    assign PCPlus8D = pcPlus8D_q;
    assign ValidD   = validD_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount_q;
    logic [31:0] bubbleCount_q;
    logic        fdUpdate;

    assign fdUpdate = FlushD | ~StallD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchCount_q  <= '0;
            bubbleCount_q <= '0;
        end else if (fdUpdate) begin
            if (validD_d) begin
                if (fetchCount_q != '1) begin
                    fetchCount_q <= fetchCount_q + 32'd1;
                end
            end else if (bubbleCount_q != '1) begin
                bubbleCount_q <= bubbleCount_q + 32'd1;
            end
        end
    end

    assign FetchCount  = fetchCount_q;
    assign BubbleCount = bubbleCount_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed vector table, multi-cycle corner sequences and a
// randomized run against a behavioural model of the fetch rules, with a variable-latency memory.
module tb_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stallD, flushD, pcSrcW, branchTakenE;
    logic [23:0] resultW, aluResultE;
    logic        imemReq, imemValid;
    logic [23:0] imemAddr, imemRData;
    logic [23:0] instrD, pcPlus8D;
    logic        validD;

    logic        rst2;
    logic        imemReq2, imemValid2, validD2;
    logic [23:0] imemAddr2, imemRData2, instrD2, pcPlus8D2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount, bubbleCount, fetchCount2, bubbleCount2;
`endif

    function automatic logic [23:0] memData(input logic [23:0] a);
        return (a ^ 24'hC0FFEE) + 24'h000011;
    endfunction

    fetch #(.N(24), .RESET_PC(24'h000000)) dut (
        .clk(clk), .rst(rst), .StallD(stallD), .FlushD(flushD),
        .PCSrcW(pcSrcW), .ResultW(resultW), .BranchTakenE(branchTakenE), .ALUResultE(aluResultE),
        .ImemReq(imemReq), .ImemAddr(imemAddr), .ImemRData(imemRData), .ImemValid(imemValid),
        .InstrD(instrD), .PCPlus8D(pcPlus8D), .ValidD(validD)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(fetchCount), .BubbleCount(bubbleCount)
`endif
    );

    // Second instance starting just below the top of the address space, on a zero-wait memory.
    assign imemValid2 = imemReq2;
    assign imemRData2 = memData(imemAddr2);

    fetch #(.N(24), .RESET_PC(24'hFFFFFC)) dut2 (
        .clk(clk), .rst(rst2), .StallD(1'b0), .FlushD(1'b0),
        .PCSrcW(1'b0), .ResultW(24'h0), .BranchTakenE(1'b0), .ALUResultE(24'h0),
        .ImemReq(imemReq2), .ImemAddr(imemAddr2), .ImemRData(imemRData2), .ImemValid(imemValid2),
        .InstrD(instrD2), .PCPlus8D(pcPlus8D2), .ValidD(validD2)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(fetchCount2), .BubbleCount(bubbleCount2)
`endif
    );

    int checks = 0;
    int fails  = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory environment: one outstanding request, latency fixed or random per request.
    bit memActive;
    int waitLeft;
    int memWait;
    bit memRandom;

    // Reference model of the fetch rules.
    logic [23:0] mPc, mReq, mHeldInstr, mHeldPc, mInstr, mPc8;
    bit          mStale, mHeld, mValid;
    int          mFetchCnt, mBubbleCnt;

    task automatic modelReset(input logic [23:0] pc);
        mPc = pc; mReq = pc; mHeldInstr = '0; mHeldPc = '0;
        mInstr = '0; mPc8 = '0; mValid = 0; mStale = 0; mHeld = 0;
        mFetchCnt = 0; mBubbleCnt = 0;
    endtask

    task automatic modelStep(input logic st, input logic fl, input logic ps, input logic [23:0] rw,
                             input logic bt, input logic [23:0] ar, input logic v, input logic [23:0] rd);
        logic        redir, cons, avail;
        logic [23:0] tgt, aInstr, aPc;
        redir = ps | bt;
        tgt = ps ? rw : ar;
        tgt[1:0] = 2'b00;
        cons = !st && !fl;
        avail = 0; aInstr = '0; aPc = '0;
        if (mHeld) begin
            if (redir) begin
                mHeld = 0; mPc = tgt; mReq = tgt;
            end else if (cons) begin
                avail = 1; aInstr = mHeldInstr; aPc = mHeldPc;
                mHeld = 0; mPc = mPc + 24'd4; mReq = mPc;
            end
        end else if (mStale) begin
            if (redir) mPc = tgt;
            if (v) begin
                mStale = 0; mReq = mPc;
            end
        end else if (v) begin
            if (redir) begin
                mPc = tgt; mReq = tgt;
            end else if (cons) begin
                avail = 1; aInstr = rd; aPc = mPc;
                mPc = mPc + 24'd4; mReq = mPc;
            end else begin
                mHeld = 1; mHeldInstr = rd; mHeldPc = mPc;
            end
        end else if (redir) begin
            mPc = tgt; mStale = 1;
        end

        if (fl) begin
            mInstr = '0; mPc8 = '0; mValid = 0; mBubbleCnt++;
        end else if (!st) begin
            if (avail) begin
                mInstr = aInstr; mPc8 = aPc + 24'd8; mValid = 1; mFetchCnt++;
            end else begin
                mInstr = '0; mValid = 0; mBubbleCnt++;
            end
        end
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic applyStimulus(input logic st, input logic fl, input logic ps, input logic [23:0] rw,
                                 input logic bt, input logic [23:0] ar);
        stallD = st; flushD = fl; pcSrcW = ps; resultW = rw; branchTakenE = bt; aluResultE = ar;
        #1;
        if (imemReq) begin
            if (!memActive) begin
                memActive = 1;
                waitLeft = memRandom ? int'($urandom_range(0, 3)) : memWait;
            end
            imemValid = (waitLeft == 0);
            imemRData = imemValid ? memData(imemAddr) : 24'($urandom);
        end else begin
            imemValid = 0;
            imemRData = 24'($urandom);
        end
        modelStep(st, fl, ps, rw, bt, ar, imemValid, imemRData);
        @(posedge clk);
        #1;
        if (memActive) begin
            if (imemValid) memActive = 0;
            else if (waitLeft > 0) waitLeft--;
        end
        imemValid = 0;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".ImemReq"}, 32'(imemReq), 32'(!mHeld));
        if (!mHeld) checkVal({tag, ".ImemAddr"}, 32'(imemAddr), 32'(mReq));
        checkVal({tag, ".InstrD"}, 32'(instrD), 32'(mInstr));
        checkVal({tag, ".PCPlus8D"}, 32'(pcPlus8D), 32'(mPc8));
        checkVal({tag, ".ValidD"}, 32'(validD), 32'(mValid));
`ifdef FETCH_PERF_CNT_EN
        checkVal({tag, ".FetchCount"}, fetchCount, 32'(mFetchCnt));
        checkVal({tag, ".BubbleCount"}, bubbleCount, 32'(mBubbleCnt));
`endif
    endtask

    task automatic doReset(input int w, input bit rnd);
        @(negedge clk);
        rst = 1;
        stallD = 0; flushD = 0; pcSrcW = 0; branchTakenE = 0; resultW = '0; aluResultE = '0;
        imemValid = 0; memActive = 0; waitLeft = 0;
        memWait = w; memRandom = rnd;
        modelReset(24'h000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("reset.ImemReq", 32'(imemReq), 32'h0);
        checkVal("reset.ImemAddr", 32'(imemAddr), 32'h0);
        checkVal("reset.ValidD", 32'(validD), 32'h0);
        rst = 0;
    endtask

    typedef struct {
        logic st, fl, ps;
        logic [23:0] rw;
        logic bt;
        logic [23:0] ar;
        logic eReq;
        logic [23:0] eAddr, eInstr, ePc8;
        logic eValid;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic st, input logic fl, input logic ps, input logic [23:0] rw,
                          input logic bt, input logic [23:0] ar, input logic eReq,
                          input logic [23:0] eAddr, input logic [23:0] eInstr,
                          input logic [23:0] ePc8, input logic eValid);
        vec_t v;
        v.st = st; v.fl = fl; v.ps = ps; v.rw = rw; v.bt = bt; v.ar = ar;
        v.eReq = eReq; v.eAddr = eAddr; v.eInstr = eInstr; v.ePc8 = ePc8; v.eValid = eValid;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        logic [23:0] firstNewAddr;
        bit gotNew;

        rst = 1; rst2 = 1;
        stallD = 0; flushD = 0; pcSrcW = 0; branchTakenE = 0; resultW = '0; aluResultE = '0;
        imemValid = 0; imemRData = '0;

        // Zero-wait vector table, starting right after reset release.
        addVec(0,0,0,24'h0,0,24'h0,       1, 24'h000004, memData(24'h000000), 24'h000008, 1);
        addVec(0,0,0,24'h0,0,24'h0,       1, 24'h000008, memData(24'h000004), 24'h00000C, 1);
        addVec(1,0,0,24'h0,0,24'h0,       0, 24'h000008, memData(24'h000004), 24'h00000C, 1);
        addVec(1,0,0,24'h0,0,24'h0,       0, 24'h000008, memData(24'h000004), 24'h00000C, 1);
        addVec(1,0,0,24'h0,0,24'h0,       0, 24'h000008, memData(24'h000004), 24'h00000C, 1);
        addVec(0,0,0,24'h0,0,24'h0,       1, 24'h00000C, memData(24'h000008), 24'h000010, 1);
        addVec(0,1,0,24'h0,0,24'h0,       0, 24'h00000C, 24'h0,               24'h000000, 0);
        addVec(0,0,0,24'h0,0,24'h0,       1, 24'h000010, memData(24'h00000C), 24'h000014, 1);
        addVec(0,0,0,24'h0,1,24'h000103,  1, 24'h000100, 24'h0,               24'h000014, 0);
        addVec(0,0,1,24'h000040,1,24'h000080, 1, 24'h000040, 24'h0,           24'h000014, 0);
        addVec(0,0,0,24'h0,0,24'h0,       1, 24'h000044, memData(24'h000040), 24'h000048, 1);
        addVec(1,1,0,24'h0,0,24'h0,       0, 24'h000044, 24'h0,               24'h000000, 0);
        addVec(0,0,0,24'h0,1,24'h000200,  1, 24'h000200, 24'h0,               24'h000000, 0);
        addVec(0,0,1,24'hFFFFFF,0,24'h0,  1, 24'hFFFFFC, 24'h0,               24'h000000, 0);
        addVec(0,0,0,24'h0,0,24'h0,       1, 24'h000000, memData(24'hFFFFFC), 24'h000004, 1);
        addVec(0,0,0,24'h0,0,24'h0,       1, 24'h000004, memData(24'h000000), 24'h000008, 1);

        doReset(0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].st, vecs[i].fl, vecs[i].ps, vecs[i].rw, vecs[i].bt, vecs[i].ar);
            checkVal($sformatf("vec%0d.ImemReq", i), 32'(imemReq), 32'(vecs[i].eReq));
            checkVal($sformatf("vec%0d.ImemAddr", i), 32'(imemAddr), 32'(vecs[i].eAddr));
            checkVal($sformatf("vec%0d.InstrD", i), 32'(instrD), 32'(vecs[i].eInstr));
            checkVal($sformatf("vec%0d.PCPlus8D", i), 32'(pcPlus8D), 32'(vecs[i].ePc8));
            checkVal($sformatf("vec%0d.ValidD", i), 32'(validD), 32'(vecs[i].eValid));
        end

        // Two wait states: one instruction every third cycle.
        doReset(2, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 24'h0, 0, 24'h0);
            checkVal($sformatf("wait2.ValidD%0d", i), 32'(validD), 32'((i % 3) == 2));
            checkOutput("wait2");
        end
`ifdef FETCH_PERF_CNT_EN
        checkVal("wait2.FetchCount", fetchCount, 32'd3);
        checkVal("wait2.BubbleRatio", bubbleCount, 2 * fetchCount);
`endif

        // Three wait states with a branch while the first request is still pending.
        doReset(3, 0);
        applyStimulus(0, 0, 0, 24'h0, 0, 24'h0);
        checkOutput("br3");
        applyStimulus(0, 0, 0, 24'h0, 1, 24'h000103);
        checkVal("br3.AddrStable", 32'(imemAddr), 32'h0);
        checkOutput("br3");
        seen = 0; gotNew = 0; firstNewAddr = '0;
        while (!validD && seen < 20) begin
            applyStimulus(0, 0, 0, 24'h0, 0, 24'h0);
            checkOutput("br3");
            if (!gotNew && imemAddr != 24'h0) begin
                gotNew = 1; firstNewAddr = imemAddr;
            end
            seen++;
        end
        checkVal("br3.Delivered", 32'(validD), 32'h1);
        checkVal("br3.NewAddr", 32'(firstNewAddr), 32'h000100);
        checkVal("br3.PCPlus8D", 32'(pcPlus8D), 32'h000108);
        checkVal("br3.InstrD", 32'(instrD), 32'(memData(24'h000100)));

        // Random latency, stalls, flushes and redirects against the model.
        doReset(0, 1);
        for (int i = 0; i < 500; i++) begin
            logic st, fl, ps, bt;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            ps = ($urandom_range(0, 19) == 0);
            bt = ($urandom_range(0, 9) == 0);
            applyStimulus(st, fl, ps, 24'($urandom), bt, 24'($urandom));
            checkOutput($sformatf("rnd%0d", i));
        end

        // Wrap-around reset PC, then reset asserted in the middle of a request.
        @(negedge clk);
        checkVal("wrap.ResetReq", 32'(imemReq2), 32'h0);
        checkVal("wrap.ResetAddr", 32'(imemAddr2), 32'hFFFFFC);
        rst2 = 0;
        @(posedge clk);
        @(negedge clk);
        checkVal("wrap.InstrD", 32'(instrD2), 32'(memData(24'hFFFFFC)));
        checkVal("wrap.PCPlus8D", 32'(pcPlus8D2), 32'h000004);
        checkVal("wrap.ValidD", 32'(validD2), 32'h1);
        checkVal("wrap.NextAddr", 32'(imemAddr2), 32'h000000);
        #2 rst2 = 1;
        #1;
        checkVal("midrst.ImemReq", 32'(imemReq2), 32'h0);
        checkVal("midrst.ImemAddr", 32'(imemAddr2), 32'hFFFFFC);
        checkVal("midrst.InstrD", 32'(instrD2), 32'h0);
        checkVal("midrst.PCPlus8D", 32'(pcPlus8D2), 32'h0);
        checkVal("midrst.ValidD", 32'(validD2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
